// File: rtl/gpio_edge_capture.sv
// Synchronise an asynchronous status vector, detect changes and queue
// timestamped {ts, value, rise, fall} events in a first-word fall-through FIFO.
module gpio_edge_capture #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TS_WIDTH    = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     capture_en,
    input  logic                     clear_ovf,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_WIDTH-1:0]      evt_ts,
    output logic [WIDTH-1:0]         evt_value,
    output logic [WIDTH-1:0]         evt_rise,
    output logic [WIDTH-1:0]         evt_fall,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               ovf_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned EW  = TS_WIDTH + 3 * WIDTH;
    localparam int unsigned ACW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    prev_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic [ACW-1:0]      arm_cnt_q, arm_cnt_d;
    logic                armed_q, armed_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         level_q, level_d;
    logic [7:0]          ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [DEPTH];

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] rise, fall;
    logic             chg, push, pop, full, wr, drop;
    logic [EW-1:0]    head;

    assign s    = sync_q[SYNC_STAGES-1];
    assign chg  = armed_q && (s != prev_q);
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;
    assign push = chg && capture_en;
    assign full = (level_q == (AW + 1)'(DEPTH));
    assign pop  = (level_q != '0) && evt_ready;
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    // Synchroniser chain, previous-value register and free-running timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev_q <= '0;
            ts_q   <= '0;
        end else begin
            sync_q[0] <= sample_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev_q <= s;
            ts_q   <= ts_q + TS_WIDTH'(1);
        end
    end

    // Arm only once the synchroniser has been flushed with real samples, so a
    // vector that is already non-zero at reset release is not seen as a change.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (arm_cnt_q != ACW'(SYNC_STAGES)) begin
            arm_cnt_d = arm_cnt_q + ACW'(1);
        end else begin
            armed_d = 1'b1;
        end
    end

    // FIFO pointer, level and overflow-counter next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (wr)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({wr, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        if (clear_ovf) begin
            ovf_d = '0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // Event storage; contents are only observable through the level-gated head.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {ts_q, s, rise, fall};
    end

    // Head presentation: outputs forced to zero while the FIFO is empty.
    always_comb begin
        head      = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
        evt_valid = (level_q != '0);
        evt_ts    = head[EW-1 -: TS_WIDTH];
        evt_value = head[3*WIDTH-1 -: WIDTH];
        evt_rise  = head[2*WIDTH-1 -: WIDTH];
        evt_fall  = head[WIDTH-1:0];
    end

    assign fifo_level = level_q;
    assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Self-checking bench for gpio_edge_capture: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_gpio_edge_capture;

    localparam int S = 2;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  smp = '0;
    logic        cap = 1'b1;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;
    logic        evt_valid;
    logic [15:0] evt_ts;
    logic [3:0]  evt_value, evt_rise, evt_fall;
    logic [3:0]  fifo_level;
    logic [7:0]  ovf_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_edge_capture #(
        .WIDTH(4), .TS_WIDTH(16), .DEPTH(D), .SYNC_STAGES(S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_in  (smp),
        .capture_en (cap),
        .clear_ovf  (clr),
        .evt_valid  (evt_valid),
        .evt_ready  (rdy),
        .evt_ts     (evt_ts),
        .evt_value  (evt_value),
        .evt_rise   (evt_rise),
        .evt_fall   (evt_fall),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    // Reference model: the synchronised value is simply the input sampled
    // S-1 edges earlier; events live in a queue.
    typedef struct packed {
        logic [15:0] ts;
        logic [3:0]  v;
        logic [3:0]  r;
        logic [3:0]  f;
    } ev_t;

    ev_t        mq[$];
    logic [3:0] hist[$];
    int         m_ovf;
    int         ecount;

    task automatic model_reset();
        mq.delete();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(4'h0);
        m_ovf  = 0;
        ecount = 0;
    endtask

    task automatic model_edge();
        logic [3:0] cur, old;
        bit         mpush, mpop;
        ev_t        e;
        cur   = hist[S-1];
        old   = hist[S];
        mpop  = (mq.size() != 0) && rdy;
        mpush = (ecount >= S + 1) && (cur != old) && cap;
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
            e.ts = ecount[15:0];
            e.v  = cur;
            e.r  = cur & ~old;
            e.f  = ~cur & old;
            if (mq.size() < D) mq.push_back(e);
            else if (!clr && m_ovf < 255) m_ovf++;
        end
        if (clr) m_ovf = 0;
        hist.push_front(smp);
        void'(hist.pop_back());
        ecount++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        ev_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("m_valid", 32'(evt_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(fifo_level), 32'(mq.size()));
        chk("m_ovf",   32'(ovf_cnt), 32'(m_ovf));
        chk("m_ts",    32'(evt_ts), 32'(h.ts));
        chk("m_value", 32'(evt_value), 32'(h.v));
        chk("m_rise",  32'(evt_rise), 32'(h.r));
        chk("m_fall",  32'(evt_fall), 32'(h.f));
    endtask

    // One clock edge with the currently driven inputs, then model check.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          rep;
        logic [3:0]  smp;
        logic        rdy;
        logic        valid;
        int          level;
        logic [15:0] ts;
        logic [3:0]  val;
        logic [3:0]  rise;
        logic [3:0]  fall;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Edges are numbered from 1 after reset release; ts equals that count.
        tbl[0] = '{10, 4'b0000, 1'b0, 1'b0, 0, 16'd0,  4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{2,  4'b0011, 1'b0, 1'b0, 0, 16'd0,  4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{1,  4'b0011, 1'b0, 1'b1, 1, 16'd12, 4'b0011, 4'b0011, 4'b0000};
        tbl[3] = '{4,  4'b0011, 1'b0, 1'b1, 1, 16'd12, 4'b0011, 4'b0011, 4'b0000};
        tbl[4] = '{1,  4'b1100, 1'b0, 1'b1, 1, 16'd12, 4'b0011, 4'b0011, 4'b0000};
        tbl[5] = '{2,  4'b1100, 1'b0, 1'b1, 2, 16'd12, 4'b0011, 4'b0011, 4'b0000};
        tbl[6] = '{1,  4'b1100, 1'b1, 1'b1, 1, 16'd19, 4'b1100, 4'b1100, 4'b0011};
        tbl[7] = '{1,  4'b1100, 1'b1, 1'b0, 0, 16'd0,  4'b0000, 4'b0000, 4'b0000};

        // Reset with a non-zero vector held: nothing must ever be logged.
        smp = 4'b0011;
        do_reset();
        repeat (20) step();
        chk("t1_valid", 32'(evt_valid), 32'd0);
        chk("t1_level", 32'(fifo_level), 32'd0);
        chk("t1_ovf",   32'(ovf_cnt), 32'd0);

        // Latency, timestamp, stability and ordered draining.
        smp = 4'b0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            smp = tbl[i].smp;
            rdy = tbl[i].rdy;
            repeat (tbl[i].rep) step();
            chk($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].level));
            chk($sformatf("tbl%0d_ts", i),    32'(evt_ts), 32'(tbl[i].ts));
            chk($sformatf("tbl%0d_value", i), 32'(evt_value), 32'(tbl[i].val));
            chk($sformatf("tbl%0d_rise", i),  32'(evt_rise), 32'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i),  32'(evt_fall), 32'(tbl[i].fall));
        end
        rdy = 1'b0;

        // Overflow: 10 changes into an 8-deep FIFO, then push+pop while full.
        smp = 4'h0;
        do_reset();
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            smp = (i % 2 == 0) ? 4'hF : 4'h0;
            step();
        end
        repeat (3) step();
        chk("t4_level_full", 32'(fifo_level), 32'd8);
        chk("t4_ovf_2",      32'(ovf_cnt), 32'd2);
        smp = 4'hF;
        step();
        step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("t4_level_pushpop", 32'(fifo_level), 32'd8);
        chk("t4_ovf_pushpop",   32'(ovf_cnt), 32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_ovf_clear", 32'(ovf_cnt), 32'd0);

        // Changes while capture is disabled are never logged later.
        smp = 4'h0;
        do_reset();
        repeat (4) step();
        cap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp = 4'(i * 3 + 1);
            step();
        end
        repeat (3) step();
        cap = 1'b1;
        repeat (5) step();
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_valid", 32'(evt_valid), 32'd0);

        // Mid-operation reset with queued events, then timestamp restart.
        smp = 4'h0;
        do_reset();
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            smp = (i % 2 == 0) ? 4'h5 : 4'h0;
            step();
        end
        repeat (2) step();
        chk("t6_level5", 32'(fifo_level), 32'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 32'd0);
        chk("t6_rst_level", 32'(fifo_level), 32'd0);
        smp = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        smp = 4'h1;
        repeat (3) step();
        chk("t6_ts_restart", 32'(evt_ts), 32'd6);
        chk("t6_value",      32'(evt_value), 32'h1);

        // Randomized traffic against the model.
        smp = 4'h0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) smp = 4'($urandom);
            cap = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
